// File: rtl/imm_gen_pipe.sv
// Purpose: pipelined RV32I immediate generator (I/S/B/U/J), sign-extended to XLEN, with illegal-opcode flag and counter.
// Latency: one cycle from input transfer to output when the output stage is empty or draining.
// Backpressure: one-entry skid buffer absorbs a stall; InReady is the registered inverse of the skid-full flag.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   InValid/InReady/InstCode input handshake and 32-bit instruction word
//   OutValid/OutReady        output handshake
//   ImmOut, ImmFmt, IllegalOp decoded immediate, format code (0 none,1 I,2 S,3 B,4 U,5 J,7 illegal), illegal flag
//   IllegalCnt               saturating count of accepted illegal instructions
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      InstCode,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [XLEN-1:0]  ImmOut,
    output logic [2:0]       ImmFmt,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] IllegalCnt
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_ILL  = 3'd7;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } dec_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic signed [31:0] imm32;
    dec_t               dec;

    always_comb begin
        imm32   = '0;
        dec.fmt = FMT_NONE;
        dec.ill = 1'b0;
        unique case (InstCode[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                // Shift immediates keep their funct bits in [11:5]; no special case.
                imm32   = 32'($signed(InstCode[31:20]));
                dec.fmt = FMT_I;
            end
            OPC_STORE: begin
                imm32   = 32'($signed({InstCode[31:25], InstCode[11:7]}));
                dec.fmt = FMT_S;
            end
            OPC_BRANCH: begin
                imm32   = 32'($signed({InstCode[31], InstCode[7], InstCode[30:25],
                                       InstCode[11:8], 1'b0}));
                dec.fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32   = {InstCode[31:12], 12'b0};
                dec.fmt = FMT_U;
            end
            OPC_JAL: begin
                imm32   = 32'($signed({InstCode[31], InstCode[19:12], InstCode[20],
                                       InstCode[30:21], 1'b0}));
                dec.fmt = FMT_J;
            end
            OPC_OP: begin
                dec.fmt = FMT_NONE;
            end
            default: begin
                dec.fmt = FMT_ILL;
                dec.ill = 1'b1;
            end
        endcase
        // imm32 is signed, so widening to 64 bits replicates bit 31.
        dec.imm = XLEN'(imm32);
    end

    // ------------------------------------------------------------------
    // Output stage plus one-entry skid buffer
    // ------------------------------------------------------------------
    logic skid_vld;
    dec_t skid_dat;
    logic out_vld;
    dec_t out_dat;
    logic in_xfer;
    logic out_free;

    assign InReady  = !skid_vld;
    assign in_xfer  = InValid && !skid_vld;
    assign out_free = !out_vld || OutReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_vld   <= 1'b0;
            skid_dat   <= '0;
            out_vld    <= 1'b0;
            out_dat    <= '0;
            IllegalCnt <= '0;
        end else begin
            if (out_free) begin
                if (skid_vld) begin
                    // Skid drains first; no input can be taken this cycle since InReady=0.
                    out_dat  <= skid_dat;
                    out_vld  <= 1'b1;
                    skid_vld <= 1'b0;
                end else if (in_xfer) begin
                    out_dat <= dec;
                    out_vld <= 1'b1;
                end else begin
                    out_vld <= 1'b0;
                end
            end else if (in_xfer) begin
                // Output stalled: park the decoded word.
                skid_dat <= dec;
                skid_vld <= 1'b1;
            end

            // Counted at acceptance regardless of where the entry lands.
            if (in_xfer && dec.ill && (IllegalCnt != CNT_MAX)) begin
                IllegalCnt <= IllegalCnt + 1'b1;
            end
        end
    end

    assign OutValid  = out_vld;
    assign ImmOut    = out_dat.imm;
    assign ImmFmt    = out_dat.fmt;
    assign IllegalOp = out_dat.ill;

endmodule
